// File: rtl/elevator_motion_ctrl.sv
// rtl/elevator_motion_ctrl.sv - elevator call scheduler and one-floor-at-a-time motion sequencer
// Optional emergency stop input iStop is compiled in when ELEV_STOP_EN is defined.
module elevator_motion_ctrl #(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_TICKS = 50000000,
  parameter int DOOR_TICKS  = 100000000,
  parameter int FW          = $clog2(N_FLOORS)
) (
  input  logic                iCLK,
  input  logic                Reset,
`ifdef ELEV_STOP_EN
  input  logic                iStop,
`endif
  input  logic [N_FLOORS-1:0] iCall,
  output logic [1:0]          oMovimento,
  output logic                oMovStrobe,
  output logic [FW-1:0]       oFloor,
  output logic                oDoorOpen,
  output logic [N_FLOORS-1:0] oPending
);

  localparam int TW = $clog2(FLOOR_TICKS);
  localparam int DW = $clog2(DOOR_TICKS);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(DOOR_TICKS - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(N_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       floor_q, floor_d, next_floor;
  logic [TW-1:0]       travel_q, travel_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic                last_up_q, last_up_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic [1:0]          mov_q, mov_d;
  logic                strobe_q, strobe_d;
  logic                door_q, door_d;

  logic [N_FLOORS-1:0] here_mask, set_mask, clr_mask;
  logic                idle_or_door, door_req, any_above, any_below, stop_w;

`ifdef ELEV_STOP_EN
  assign stop_w = iStop;
`else
  assign stop_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    travel_d   = travel_q;
    dwell_d    = dwell_q;
    last_up_d  = last_up_q;
    clr_mask   = '0;
    next_floor = floor_q;

    here_mask    = N_FLOORS'(1) << floor_q;
    idle_or_door = (state_q == IDLE) || (state_q == DOOR_OPEN);
    // A call for the floor the car is parked at is a door request, never a pending call.
    door_req     = idle_or_door && |(iCall & here_mask);
    set_mask     = idle_or_door ? (iCall & ~here_mask) : iCall;

    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (pending_q[i]) begin
        if (i > int'(floor_q)) any_above = 1'b1;
        if (i < int'(floor_q)) any_below = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (door_req) begin
          state_d = DOOR_OPEN;
          dwell_d = '0;
        end else if (any_above && (last_up_q || !any_below)) begin
          state_d   = MOVE_UP;
          travel_d  = '0;
          last_up_d = 1'b1;
        end else if (any_below) begin
          state_d   = MOVE_DOWN;
          travel_d  = '0;
          last_up_d = 1'b0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if ((state_q == MOVE_UP && floor_q == TOP_FLOOR) ||
            (state_q == MOVE_DOWN && floor_q == '0)) begin
          state_d = IDLE;
        end else if (!stop_w) begin
          if (travel_q == TRAVEL_LAST) begin
            travel_d   = '0;
            next_floor = (state_q == MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
            floor_d    = next_floor;
            // Arrival test includes a call raised on this very edge.
            if (pending_q[next_floor] || iCall[next_floor]) begin
              state_d  = DOOR_OPEN;
              dwell_d  = '0;
              clr_mask = N_FLOORS'(1) << next_floor;
            end
          end else begin
            travel_d = travel_q + TW'(1);
          end
        end
      end
      DOOR_OPEN: begin
        if (door_req) begin
          dwell_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    pending_d = (pending_q | set_mask) & ~clr_mask;

    mov_d = 2'd0;
    if (!stop_w) begin
      if (state_d == MOVE_UP)        mov_d = 2'd1;
      else if (state_d == MOVE_DOWN) mov_d = 2'd2;
    end
    strobe_d = (mov_d != mov_q);
    door_d   = (state_d == DOOR_OPEN);
  end

  always_ff @(posedge iCLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      travel_q  <= '0;
      dwell_q   <= '0;
      last_up_q <= 1'b1;
      pending_q <= '0;
      mov_q     <= 2'd0;
      strobe_q  <= 1'b0;
      door_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      travel_q  <= travel_d;
      dwell_q   <= dwell_d;
      last_up_q <= last_up_d;
      pending_q <= pending_d;
      mov_q     <= mov_d;
      strobe_q  <= strobe_d;
      door_q    <= door_d;
    end
  end

  assign oMovimento = mov_q;
  assign oMovStrobe = strobe_q;
  assign oFloor     = floor_q;
  assign oDoorOpen  = door_q;
  assign oPending   = pending_q;

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// tb/tb_elevator_motion_ctrl.sv - self-checking bench for elevator_motion_ctrl
// Expected behaviour comes from a trip-level schedule model (leg start/arrival times by arithmetic).
module tb_elevator_motion_ctrl;
  localparam int NF = 4;
  localparam int FT = 4;
  localparam int DT = 6;

  logic          iCLK;
  logic          Reset;
  logic [NF-1:0] iCall;
  logic [1:0]    oMovimento;
  logic          oMovStrobe;
  logic [1:0]    oFloor;
  logic          oDoorOpen;
  logic [NF-1:0] oPending;
`ifdef ELEV_STOP_EN
  logic          iStop;
`endif

  elevator_motion_ctrl #(
    .N_FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT), .FW(2)
  ) dut (
    .iCLK(iCLK),
    .Reset(Reset),
`ifdef ELEV_STOP_EN
    .iStop(iStop),
`endif
    .iCall(iCall),
    .oMovimento(oMovimento),
    .oMovStrobe(oMovStrobe),
    .oFloor(oFloor),
    .oDoorOpen(oDoorOpen),
    .oPending(oPending)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_floor;
  bit m_last_up;

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%b exp=0", {oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe});
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe} !== 10'd0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=0", cyc, {oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe});
      end
    end
  endtask

  task automatic test_single_call();
    int t;
    iCall = 4'b0100; tick(); t = cyc; iCall = '0;
    n_cmp++;
    if ({oPending, oMovimento} !== {4'b0100, 2'd0}) begin
      n_bad++; $display("FAIL single_latch got=%b/%0d exp=0100/0", oPending, oMovimento);
    end
    tick();
    n_cmp++;
    if ({oMovimento, oMovStrobe} !== {2'd1, 1'b1}) begin
      n_bad++; $display("FAIL single_start got=%0d/%b exp=1/1", oMovimento, oMovStrobe);
    end
    repeat (4) tick();
    n_cmp++;
    if ({oFloor, oMovimento, oMovStrobe} !== {2'd1, 2'd1, 1'b0}) begin
      n_bad++; $display("FAIL single_floor1 cyc=%0d got=%0d/%0d/%b exp=1/1/0", cyc - t, oFloor, oMovimento, oMovStrobe);
    end
    repeat (4) tick();
    n_cmp++;
    if ({oFloor, oDoorOpen, oMovimento, oMovStrobe, oPending} !== {2'd2, 1'b1, 2'd0, 1'b1, 4'b0000}) begin
      n_bad++;
      $display("FAIL single_arrive got=%b exp=%b", {oFloor, oDoorOpen, oMovimento, oMovStrobe, oPending},
               {2'd2, 1'b1, 2'd0, 1'b1, 4'b0000});
    end
    repeat (5) tick();
    n_cmp++;
    if (oDoorOpen !== 1'b1) begin
      n_bad++; $display("FAIL single_dwell got=%b exp=1", oDoorOpen);
    end
    tick();
    n_cmp++;
    if ({oDoorOpen, oMovimento} !== 3'b000) begin
      n_bad++; $display("FAIL single_idle at t+%0d got=%b/%0d exp=0/0", cyc - t, oDoorOpen, oMovimento);
    end
    m_floor = 2; m_last_up = 1'b1;
  endtask

  // Pulses a call mask from IDLE and checks every cycle against the modelled trip schedule.
  task automatic run_scenario(input logic [3:0] m_in);
    logic [3:0] m, rem, ep;
    logic [8:0] ev, av;
    logic [1:0] pm;
    logic       ed, es;
    int ls[$], la[$], lf[$], lt[$], ld[$];
    int f, t0, tnext, last_end, nxt, c, em, ef;
    bit up, above, below;
    m = m_in & ~(4'b0001 << m_floor);
    if (m == 4'b0000) return;
    iCall = m; tick(); t0 = cyc; iCall = '0;
    n_cmp++;
    if (oPending !== m) begin
      n_bad++; $display("FAIL scen_latch got=%b exp=%b", oPending, m);
    end
    f = m_floor; up = m_last_up; rem = m; tnext = t0 + 1; last_end = t0;
    while (rem != 4'b0000) begin
      above = 0; below = 0;
      for (int k = 0; k < NF; k++) if (rem[k]) begin
        if (k > f) above = 1;
        if (k < f) below = 1;
      end
      nxt = 0;
      if (above && (up || !below)) begin
        up = 1;
        for (int k = NF - 1; k > f; k--) if (rem[k]) nxt = k;
        ld.push_back(1);
      end else begin
        up = 0;
        for (int k = 0; k < f; k++) if (rem[k]) nxt = k;
        ld.push_back(-1);
      end
      ls.push_back(tnext); lf.push_back(f); lt.push_back(nxt);
      la.push_back(tnext + ((nxt > f) ? (nxt - f) : (f - nxt)) * FT);
      rem[nxt] = 1'b0; f = nxt;
      tnext = la[la.size() - 1] + DT + 1;
      last_end = la[la.size() - 1] + DT;
    end
    m_floor = f; m_last_up = up;
    pm = oMovimento;
    while (cyc < last_end + 1) begin
      tick(); c = cyc;
      em = 0; ef = lf[0]; ed = 1'b0; ep = m;
      for (int j = 0; j < ls.size(); j++) begin
        if (c >= la[j]) begin
          ef = lt[j]; ep[lt[j]] = 1'b0;
          if (c < la[j] + DT) ed = 1'b1;
        end else if (c >= ls[j]) begin
          em = (ld[j] > 0) ? 1 : 2;
          ef = lf[j] + ld[j] * ((c - ls[j]) / FT);
        end
      end
      ev = {2'(em), 2'(ef), ed, ep};
      av = {oMovimento, oFloor, oDoorOpen, oPending};
      n_cmp++;
      if (av !== ev) begin
        n_bad++; $display("FAIL scen_outputs t0+%0d got=%b exp=%b", c - t0, av, ev);
      end
      es = (oMovimento !== pm);
      n_cmp++;
      if (oMovStrobe !== es) begin
        n_bad++; $display("FAIL scen_strobe t0+%0d got=%b exp=%b", c - t0, oMovStrobe, es);
      end
      pm = oMovimento;
    end
  endtask

  task automatic test_door_restart();
    int t0, a;
    run_scenario(4'b0001);
    iCall = 4'b0100; tick(); t0 = cyc; iCall = '0;
    a = t0 + 1 + 2 * FT;
    while (cyc < a + 4) tick();
    n_cmp++;
    if ({oDoorOpen, oFloor} !== {1'b1, 2'd2}) begin
      n_bad++; $display("FAIL restart_open got=%b/%0d exp=1/2", oDoorOpen, oFloor);
    end
    iCall = 4'b0100; tick(); iCall = '0;
    n_cmp++;
    if ({oDoorOpen, oPending} !== {1'b1, 4'b0000}) begin
      n_bad++; $display("FAIL restart_req got=%b/%b exp=1/0000", oDoorOpen, oPending);
    end
    while (oDoorOpen === 1'b1 && cyc < a + 40) tick();
    n_cmp++;
    if (cyc !== a + 11) begin
      n_bad++; $display("FAIL restart_len got=%0d exp=11", cyc - a);
    end
    m_floor = 2; m_last_up = 1'b1;
  endtask

`ifdef ELEV_STOP_EN
  task automatic test_stop();
    int t0;
    run_scenario(4'b0001);
    iCall = 4'b0010; tick(); t0 = cyc; iCall = '0;
    repeat (3) tick();
    iStop = 1'b1; tick();
    n_cmp++;
    if ({oMovimento, oMovStrobe} !== {2'd0, 1'b1}) begin
      n_bad++; $display("FAIL stop_freeze got=%0d/%b exp=0/1", oMovimento, oMovStrobe);
    end
    repeat (4) tick();
    n_cmp++;
    if ({oMovimento, oMovStrobe, oFloor} !== {2'd0, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL stop_hold got=%0d/%b/%0d exp=0/0/0", oMovimento, oMovStrobe, oFloor);
    end
    iStop = 1'b0; tick();
    n_cmp++;
    if ({oMovimento, oMovStrobe} !== {2'd1, 1'b1}) begin
      n_bad++; $display("FAIL stop_resume got=%0d/%b exp=1/1", oMovimento, oMovStrobe);
    end
    tick();
    n_cmp++;
    if ({oFloor, oDoorOpen, oMovimento} !== {2'd1, 1'b1, 2'd0}) begin
      n_bad++; $display("FAIL stop_arrive t0+%0d got=%0d/%b/%0d exp=1/1/0", cyc - t0, oFloor, oDoorOpen, oMovimento);
    end
    while (cyc < t0 + 10 + DT + 1) tick();
    m_floor = 1; m_last_up = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_move();
    run_scenario(4'b0001);
    iCall = 4'b1000; tick(); iCall = '0;
    repeat (6) tick();
    #3;
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe} !== 10'd0) begin
      n_bad++; $display("FAIL async_reset got=%b exp=0", {oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe});
    end
    tick();
    Reset = 1'b0;
    m_floor = 0; m_last_up = 1'b1;
    tick();
    n_cmp++;
    if ({oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe} !== 10'd0) begin
      n_bad++; $display("FAIL post_reset got=%b exp=0", {oMovimento, oFloor, oDoorOpen, oPending, oMovStrobe});
    end
    run_scenario(4'b0010);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) run_scenario(4'($urandom_range(1, 15)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1; iCall = '0;
`ifdef ELEV_STOP_EN
    iStop = 1'b0;
`endif
    m_floor = 0; m_last_up = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    test_reset();
    test_single_call();
    test_door_restart();
    run_scenario(4'b0001);
    run_scenario(4'b1010);
    run_scenario(4'b0101);
    test_random();
`ifdef ELEV_STOP_EN
    test_stop();
`endif
    test_reset_mid_move();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
